// File: rtl/checkpoint_manager.sv
// checkpoint_manager: circular buffer of branch checkpoints. Slots are
// allocated at tail, marked ok by correct resolves, and released in order
// from head. A mispredict squashes the resolved slot and everything younger.
// Each release or squash produces a one-cycle command pulse to the register file.
// Optional feature macro: CHKMGR_ALLOC_BYPASS_EN. When it is defined, a full
// queue still accepts an allocation in a cycle where head is released.
module checkpoint_manager #(
    parameter int name_width = 1,
    parameter int slot_width = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ALLOC_E,
    input  logic [name_width-1:0] CHK_IN,
    output logic                  ALLOC_READY,
    output logic [slot_width-1:0] ID_OUT,
    output logic                  CHK_REQ,
    input  logic                  RES_E,
    input  logic [slot_width-1:0] RES_ID,
    input  logic                  RES_MISPRED,
    output logic                  ROLLBK_E,
    output logic                  DO_ROLL,
    output logic                  DO_REL,
    output logic [name_width-1:0] ROLLBK_OUT,
    output logic [slot_width:0]   COUNT
);

    localparam int N = 2 ** slot_width;
    localparam logic [slot_width:0] FULL = (slot_width + 1)'(N);

    logic [N-1:0]          valid_q, valid_d;
    logic [N-1:0]          ok_q, ok_d;
    logic [name_width-1:0] name_q [N];
    logic [slot_width-1:0] head_q, head_d;
    logic [slot_width-1:0] tail_q, tail_d;
    logic [slot_width:0]   count_q, count_d;
    logic                  rollbk_e_q, rollbk_e_d;
    logic                  do_roll_q, do_roll_d;
    logic                  do_rel_q, do_rel_d;
    logic [name_width-1:0] rollbk_out_q, rollbk_out_d;

    logic                  res_hit;
    logic                  mispred;
    logic                  res_ok;
    logic                  rel_now;
    logic                  full;
    logic                  alloc_ready;
    logic                  alloc_fire;
    logic [slot_width-1:0] roll_off;

    // Decode the resolve port and the release / allocation decisions for this cycle.
    always_comb begin
        res_hit  = RES_E && !RST && valid_q[RES_ID];
        mispred  = res_hit && RES_MISPRED;
        res_ok   = res_hit && !RES_MISPRED;
        rel_now  = !RST && !mispred && valid_q[head_q]
                   && (ok_q[head_q] || (res_ok && (RES_ID == head_q)));
        full     = (count_q == FULL);
        roll_off = RES_ID - head_q;
`ifdef CHKMGR_ALLOC_BYPASS_EN
        // A full queue may still allocate into the slot head vacates this cycle.
        alloc_ready = (!full || rel_now) && !mispred;
`else
        alloc_ready = !full && !mispred;
`endif
        alloc_fire = ALLOC_E && alloc_ready && !RST;
    end

    // Next-state of the slot table, pointers, count and the command pulse.
    always_comb begin
        valid_d      = valid_q;
        ok_d         = ok_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        rollbk_e_d   = 1'b0;
        do_roll_d    = 1'b0;
        do_rel_d     = 1'b0;
        rollbk_out_d = rollbk_out_q;
        if (mispred) begin
            // Squash the mispredicted slot and every slot younger than it.
            for (int i = 0; i < N; i++) begin
                if ((slot_width'(i) - head_q) >= roll_off) begin
                    valid_d[i] = 1'b0;
                    ok_d[i]    = 1'b0;
                end
            end
            tail_d       = RES_ID;
            count_d      = {1'b0, roll_off};
            rollbk_e_d   = 1'b1;
            do_roll_d    = 1'b1;
            rollbk_out_d = name_q[RES_ID];
        end else begin
            if (res_ok) begin
                ok_d[RES_ID] = 1'b1;
            end
            if (rel_now) begin
                valid_d[head_q] = 1'b0;
                ok_d[head_q]    = 1'b0;
                head_d          = head_q + 1'b1;
                rollbk_e_d      = 1'b1;
                do_rel_d        = 1'b1;
                rollbk_out_d    = name_q[head_q];
            end
            // Allocation is applied last so it wins when tail wraps onto the released head.
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                ok_d[tail_q]    = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            count_d = count_q + (slot_width + 1)'(alloc_fire) - (slot_width + 1)'(rel_now);
        end
    end

    // Control state and command pulse registers, cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q      <= '0;
            ok_q         <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rollbk_e_q   <= 1'b0;
            do_roll_q    <= 1'b0;
            do_rel_q     <= 1'b0;
            rollbk_out_q <= '0;
        end else begin
            valid_q      <= valid_d;
            ok_q         <= ok_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rollbk_e_q   <= rollbk_e_d;
            do_roll_q    <= do_roll_d;
            do_rel_q     <= do_rel_d;
            rollbk_out_q <= rollbk_out_d;
        end
    end

    // Checkpoint names are pure data; they are written on allocation and never reset.
    always_ff @(posedge CLK) begin
        if (alloc_fire) begin
            name_q[tail_q] <= CHK_IN;
        end
    end

    assign ALLOC_READY = alloc_ready;
    assign CHK_REQ     = alloc_fire;
    assign ID_OUT      = tail_q;
    assign ROLLBK_E    = rollbk_e_q;
    assign DO_ROLL     = do_roll_q;
    assign DO_REL      = do_rel_q;
    assign ROLLBK_OUT  = rollbk_out_q;
    assign COUNT       = count_q;

endmodule

// File: tb/tb_checkpoint_manager.sv
// Bench for checkpoint_manager (name_width=4, slot_width=2, N=4). A queue-based
// model of live checkpoints in age order predicts every output each cycle;
// literal expectations from hand-worked scenarios pin the model.
module tb_checkpoint_manager;

    localparam int NW = 4;
    localparam int SW = 2;
    localparam int NS = 4;
`ifdef CHKMGR_ALLOC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          ALLOC_E = 1'b0;
    logic [NW-1:0] CHK_IN = '0;
    logic          ALLOC_READY;
    logic [SW-1:0] ID_OUT;
    logic          CHK_REQ;
    logic          RES_E = 1'b0;
    logic [SW-1:0] RES_ID = '0;
    logic          RES_MISPRED = 1'b0;
    logic          ROLLBK_E;
    logic          DO_ROLL;
    logic          DO_REL;
    logic [NW-1:0] ROLLBK_OUT;
    logic [SW:0]   COUNT;

    checkpoint_manager #(.name_width(NW), .slot_width(SW)) dut (
        .CLK(CLK), .RST(RST), .ALLOC_E(ALLOC_E), .CHK_IN(CHK_IN),
        .ALLOC_READY(ALLOC_READY), .ID_OUT(ID_OUT), .CHK_REQ(CHK_REQ),
        .RES_E(RES_E), .RES_ID(RES_ID), .RES_MISPRED(RES_MISPRED),
        .ROLLBK_E(ROLLBK_E), .DO_ROLL(DO_ROLL), .DO_REL(DO_REL),
        .ROLLBK_OUT(ROLLBK_OUT), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [SW-1:0] id;
        logic [NW-1:0] nm;
        bit            ok;
    } ent_t;

    ent_t          mq[$];
    logic [SW-1:0] mtail = '0;
    bit            e_rb = 1'b0, e_roll = 1'b0, e_rel = 1'b0;
    logic [NW-1:0] e_out = '0;
    logic [SW-1:0] last_id;
    logic          last_ready;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, advance the model, then check registered outputs after the edge.
    task automatic step(input bit rst, input bit al, input logic [NW-1:0] nm,
                        input bit re, input logic [SW-1:0] rid, input bit mp);
        int k;
        bit mis, good, rel, rdy, fire;
        @(negedge CLK);
        RST = rst; ALLOC_E = al; CHK_IN = nm; RES_E = re; RES_ID = rid; RES_MISPRED = mp;
        #1;
        if (rst) begin
            mq.delete();
            mtail = '0;
            e_rb = 0; e_roll = 0; e_rel = 0; e_out = '0;
        end else begin
            k = -1;
            foreach (mq[j]) if (mq[j].id == rid) k = j;
            mis  = re && (k >= 0) && mp;
            good = re && (k >= 0) && !mp;
            rel  = (mq.size() > 0) && !mis && (mq[0].ok || (good && k == 0));
            rdy  = !mis && ((mq.size() < NS) || (BYP && rel));
            fire = al && rdy;
            chk("alloc_ready", ALLOC_READY, rdy);
            chk("chk_req", CHK_REQ, fire);
            chk("id_out", ID_OUT, mtail);
            last_id = ID_OUT;
            last_ready = ALLOC_READY;
            e_rb = 0; e_roll = 0; e_rel = 0;
            if (mis) begin
                e_rb = 1; e_roll = 1; e_out = mq[k].nm;
                while (mq.size() > k) mq.delete(mq.size() - 1);
                mtail = rid;
            end else begin
                if (good) mq[k].ok = 1'b1;
                if (rel) begin
                    e_rb = 1; e_rel = 1; e_out = mq[0].nm;
                    mq.delete(0);
                end
                if (fire) begin
                    mq.push_back('{id: mtail, nm: nm, ok: 1'b0});
                    mtail = mtail + 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
        chk("rollbk_e", ROLLBK_E, e_rb);
        chk("do_roll", DO_ROLL, e_roll);
        chk("do_rel", DO_REL, e_rel);
        chk("rollbk_out", ROLLBK_OUT, e_out);
        chk("count", COUNT, mq.size());
    endtask

    task automatic idle();
        step(0, 0, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        // Inputs asserted during reset must be ignored.
        step(1, 1, 4'hF, 1, 2'd0, 1);
    endtask

    task automatic alloc(input logic [NW-1:0] nm);
        step(0, 1, nm, 0, '0, 0);
    endtask

    initial begin
        // Reset state.
        do_reset();
        chk("rst_count", COUNT, 0);
        chk("rst_ready", ALLOC_READY, 1);
        chk("rst_id", ID_OUT, 0);
        chk("rst_rollbk_e", ROLLBK_E, 0);
        chk("rst_rollbk_out", ROLLBK_OUT, 0);

        // Resolve of a never-allocated slot: ignored.
        step(0, 0, '0, 1, 2'd3, 1);
        chk("inval_res_no_pulse", ROLLBK_E, 0);
        chk("inval_res_ready", last_ready, 1);

        // In-order release.
        alloc(4'd5); chk("a33_id0", last_id, 0);
        alloc(4'd6); chk("a33_id1", last_id, 1);
        alloc(4'd7); chk("a33_id2", last_id, 2);
        chk("a33_count3", COUNT, 3);
        step(0, 0, '0, 1, 2'd1, 0);
        chk("a33_res1_no_pulse", ROLLBK_E, 0);
        step(0, 0, '0, 1, 2'd0, 0);
        chk("a33_rel_a", DO_REL, 1);
        chk("a33_out5", ROLLBK_OUT, 5);
        idle();
        chk("a33_rel_b", DO_REL, 1);
        chk("a33_out6", ROLLBK_OUT, 6);
        idle();
        chk("a33_slot2_pending", ROLLBK_E, 0);
        chk("a33_count1", COUNT, 1);

        // Mispredict in the middle of a full queue.
        do_reset();
        alloc(4'd8); alloc(4'd9); alloc(4'd10); alloc(4'd11);
        chk("a34_full", COUNT, 4);
        step(0, 1, 4'd12, 0, '0, 0);
        chk("a34_full_not_ready", last_ready, 0);
        step(0, 0, '0, 1, 2'd1, 1);
        chk("a34_roll", DO_ROLL, 1);
        chk("a34_out9", ROLLBK_OUT, 9);
        chk("a34_count1", COUNT, 1);
        alloc(4'd12);
        chk("a34_next_id1", last_id, 1);

        // Full queue, head resolved ok with a simultaneous allocation.
        do_reset();
        alloc(4'd1); alloc(4'd2); alloc(4'd3); alloc(4'd4);
        step(0, 1, 4'd13, 1, 2'd0, 0);
        chk("a35_rel", DO_REL, 1);
        chk("a35_out1", ROLLBK_OUT, 1);
        if (BYP) begin
            chk("a35_byp_ready", last_ready, 1);
            chk("a35_byp_id", last_id, 0);
            chk("a35_byp_count", COUNT, 4);
        end else begin
            chk("a35_ready", last_ready, 0);
            chk("a35_count", COUNT, 3);
        end

        // Mispredict takes priority over a pending head release.
        do_reset();
        alloc(4'd1); alloc(4'd2); alloc(4'd3); alloc(4'd4);
        step(0, 0, '0, 1, 2'd1, 0);
        step(0, 0, '0, 1, 2'd0, 0);
        chk("a36_rel0", DO_REL, 1);
        step(0, 0, '0, 1, 2'd2, 1);
        chk("a36_roll_first", DO_ROLL, 1);
        chk("a36_roll_no_rel", DO_REL, 0);
        chk("a36_roll_out3", ROLLBK_OUT, 3);
        chk("a36_roll_count1", COUNT, 1);
        idle();
        chk("a36_rel_after", DO_REL, 1);
        chk("a36_rel_out2", ROLLBK_OUT, 2);
        chk("a36_empty", COUNT, 0);

        // Mispredict of head in a full queue empties it.
        do_reset();
        alloc(4'd1); alloc(4'd2); alloc(4'd3); alloc(4'd4);
        step(0, 0, '0, 1, 2'd0, 1);
        chk("head_mis_count0", COUNT, 0);
        chk("head_mis_out1", ROLLBK_OUT, 1);
        alloc(4'd9);
        chk("head_mis_realloc_id0", last_id, 0);

        // Wrap-around with alloc/release pairs.
        do_reset();
        alloc(4'd0);
        chk("wrap_id_0", last_id, 0);
        for (int i = 1; i < 10; i++) begin
            step(0, 1, NW'(i), 1, SW'(i - 1), 0);
            chk("wrap_id", last_id, i % 4);
            chk("wrap_count_le1", (COUNT <= 1), 1);
        end
        step(0, 0, '0, 1, 2'd1, 0);
        chk("wrap_last_out9", ROLLBK_OUT, 9);
        chk("wrap_empty", COUNT, 0);

        // Reset mid-operation with live slots and a release that would pulse.
        do_reset();
        alloc(4'd1); alloc(4'd2); alloc(4'd3);
        step(0, 0, '0, 1, 2'd1, 0);
        do_reset();
        chk("a38_count0", COUNT, 0);
        chk("a38_ready", ALLOC_READY, 1);
        chk("a38_no_pulse", ROLLBK_E, 0);
        idle();
        chk("a38_no_pulse_after", ROLLBK_E, 0);
        chk("a38_id0", ID_OUT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
